// File: rtl/ppu_fb_writer.sv
// ppu_fb_writer
// Captures PPU pixels whenever the beam pointer moves to a new coordinate,
// queues them in a FIFO, and writes them to the frame buffer through a
// request/acknowledge handshake.
//
// Ports
//   PPU_SLOW_CLOCK  : clock, all state updates on its rising edge
//   RST             : asynchronous active-high reset
//   ENABLE          : capture enable (queued entries still drain when low)
//   VGA_STREAM_DATA : 6-bit colour index of the current pixel
//   PPU_PTR_X/Y     : current pixel column / scanline
//   FB_ADDR/FB_DATA : frame-buffer write address {Y,X} and data
//   FB_WE           : write request, held until FB_ACK is sampled high
//   FB_ACK          : write accepted by the memory
//   FRAME_DONE      : one-cycle pulse after the write to 0xEFFF is accepted
//   OVERFLOW        : sticky, set when a capture is dropped on a full FIFO
//   DROP_COUNT      : saturating count of dropped captures
module ppu_fb_writer #(
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic        PPU_SLOW_CLOCK,
   input  logic        RST,
   input  logic        ENABLE,
   input  logic [5:0]  VGA_STREAM_DATA,
   input  logic [7:0]  PPU_PTR_X,
   input  logic [7:0]  PPU_PTR_Y,
   output logic [15:0] FB_ADDR,
   output logic [5:0]  FB_DATA,
   output logic        FB_WE,
   input  logic        FB_ACK,
   output logic        FRAME_DONE,
   output logic        OVERFLOW,
   output logic [7:0]  DROP_COUNT
);

   localparam int unsigned PW   = $clog2(FIFO_DEPTH);
   localparam int unsigned PTRW = PW + 1;
   localparam int unsigned AW   = 16;
   localparam int unsigned DW   = 6;
   localparam int unsigned EW   = AW + DW;
   localparam int unsigned CW   = 8;

   localparam logic [AW-1:0] LAST_ADDR = 16'hEFFF;
   localparam logic [7:0]    RST_X     = 8'd255;
   localparam logic [7:0]    RST_Y     = 8'd239;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   // State
   state_t            r_state;
   logic [7:0]        r_prev_x;
   logic [7:0]        r_prev_y;
   logic [PTRW-1:0]   r_wr_ptr;
   logic [PTRW-1:0]   r_rd_ptr;
   logic [EW-1:0]     r_mem [FIFO_DEPTH];
   logic              r_we;
   logic [AW-1:0]     r_addr;
   logic [DW-1:0]     r_data;
   logic              r_frame_done;
   logic              r_overflow;
   logic [CW-1:0]     r_drop_count;

   // Combinational
   state_t            w_state_nxt;
   logic              w_we_nxt;
   logic [AW-1:0]     w_addr_nxt;
   logic [DW-1:0]     w_data_nxt;
   logic              w_frame_done_nxt;
   logic              w_pop;
   logic              w_capture;
   logic              w_push;
   logic              w_drop;
   logic              w_empty;
   logic              w_full;
   logic              w_more;
   logic [PTRW-1:0]   w_count;
   logic [PTRW-1:0]   w_rd_ptr_inc;
   logic [EW-1:0]     w_head;
   logic [EW-1:0]     w_next;

   assign FB_ADDR    = r_addr;
   assign FB_DATA    = r_data;
   assign FB_WE      = r_we;
   assign FRAME_DONE = r_frame_done;
   assign OVERFLOW   = r_overflow;
   assign DROP_COUNT = r_drop_count;

   // Capture on a coordinate change; blanking repeats of the clamped pointer collapse to one.
   assign w_capture = ENABLE && ({PPU_PTR_Y, PPU_PTR_X} != {r_prev_y, r_prev_x});

   // Full is judged on the current pointers, so a same-edge pop does not rescue a capture.
   assign w_count  = r_wr_ptr - r_rd_ptr;
   assign w_empty  = (r_wr_ptr == r_rd_ptr);
   assign w_full   = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                     (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
   assign w_push   = w_capture && !w_full;
   assign w_drop   = w_capture && w_full;

   // The entry in the output register stays in the FIFO until acknowledged,
   // so the output register counts toward FIFO_DEPTH.
   assign w_more       = (w_count > PTRW'(1));
   assign w_rd_ptr_inc = r_rd_ptr + PTRW'(1);
   assign w_head       = r_mem[r_rd_ptr[PW-1:0]];
   assign w_next       = r_mem[w_rd_ptr_inc[PW-1:0]];

   // FIFO storage (no reset needed; validity tracked by the pointers)
   always_ff @(posedge PPU_SLOW_CLOCK) begin
      if (w_push) begin
         r_mem[r_wr_ptr[PW-1:0]] <= {PPU_PTR_Y, PPU_PTR_X, VGA_STREAM_DATA};
      end
   end

   // Write FSM next-state and output logic
   always_comb begin
      w_state_nxt      = r_state;
      w_we_nxt         = r_we;
      w_addr_nxt       = r_addr;
      w_data_nxt       = r_data;
      w_frame_done_nxt = 1'b0;
      w_pop            = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               {w_addr_nxt, w_data_nxt} = w_head;
               w_we_nxt                 = 1'b1;
               w_state_nxt              = REQ;
            end
         end
         REQ: begin
            if (FB_ACK) begin
               w_pop            = 1'b1;
               w_frame_done_nxt = (r_addr == LAST_ADDR);
               if (w_more) begin
                  {w_addr_nxt, w_data_nxt} = w_next;
               end else begin
                  w_we_nxt    = 1'b0;
                  w_state_nxt = IDLE;
               end
            end
         end
         default: begin
            w_we_nxt    = 1'b0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State, output and FIFO pointer registers
   always_ff @(posedge PPU_SLOW_CLOCK or posedge RST) begin
      if (RST) begin
         r_state      <= IDLE;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_data       <= '0;
         r_frame_done <= 1'b0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_prev_x     <= RST_X;
         r_prev_y     <= RST_Y;
      end else begin
         r_state      <= w_state_nxt;
         r_we         <= w_we_nxt;
         r_addr       <= w_addr_nxt;
         r_data       <= w_data_nxt;
         r_frame_done <= w_frame_done_nxt;
         r_prev_x     <= PPU_PTR_X;
         r_prev_y     <= PPU_PTR_Y;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTRW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= w_rd_ptr_inc;
         end
      end
   end

   // Sticky overflow flag and saturating drop counter
   always_ff @(posedge PPU_SLOW_CLOCK or posedge RST) begin
      if (RST) begin
         r_overflow   <= 1'b0;
         r_drop_count <= '0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (r_drop_count != {CW{1'b1}}) begin
            r_drop_count <= r_drop_count + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_ppu_fb_writer.sv
// Scoreboard bench for ppu_fb_writer: directed pixel streams push expected
// {addr,data} entries; a negedge monitor pops and compares every accepted write.
module tb_ppu_fb_writer;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        ack;
   logic [5:0]  vdata;
   logic [7:0]  px;
   logic [7:0]  py;
   logic [15:0] fb_addr;
   logic [5:0]  fb_data;
   logic        fb_we;
   logic        frame_done;
   logic        overflow;
   logic [7:0]  drop_count;

   int checks   = 0;
   int errors   = 0;
   int n_writes = 0;
   int fd_total = 0;
   int w0;
   int f0;
   logic [21:0] exp_q[$];
   logic [21:0] mon_e;

   always #5 clk = ~clk;

   ppu_fb_writer #(.FIFO_DEPTH(16)) dut (
      .PPU_SLOW_CLOCK  (clk),
      .RST             (rst),
      .ENABLE          (en),
      .VGA_STREAM_DATA (vdata),
      .PPU_PTR_X       (px),
      .PPU_PTR_Y       (py),
      .FB_ADDR         (fb_addr),
      .FB_DATA         (fb_data),
      .FB_WE           (fb_we),
      .FB_ACK          (ack),
      .FRAME_DONE      (frame_done),
      .OVERFLOW        (overflow),
      .DROP_COUNT      (drop_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a pixel for one edge; optionally record the write it must produce.
   task automatic pix(input logic [7:0] x, input logic [7:0] y, input logic [5:0] d, input bit expect_wr);
      px    = x;
      py    = y;
      vdata = d;
      if (expect_wr) exp_q.push_back({y, x, d});
      tick();
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || fb_we !== 1'b0) && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 200) begin
         errors++;
         $display("FAIL %s_drain: got %0d pending expected 0", name, exp_q.size());
      end
   endtask

   // Monitor: every handshake seen before the edge is a write the memory accepts.
   always @(negedge clk) begin
      if (frame_done === 1'b1) fd_total++;
      if (rst === 1'b0 && fb_we === 1'b1 && ack === 1'b1) begin
         n_writes++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr 0x%04h data 0x%02h expected none", fb_addr, fb_data);
         end else begin
            mon_e = exp_q.pop_front();
            check("write_addr", 32'(fb_addr), 32'(mon_e[21:6]));
            check("write_data", 32'(fb_data), 32'(mon_e[5:0]));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst   = 1'b1;
      en    = 1'b0;
      ack   = 1'b0;
      px    = 8'd255;
      py    = 8'd239;
      vdata = 6'd0;
      repeat (2) tick();
      check("rst_we",       32'(fb_we),      0);
      check("rst_addr",     32'(fb_addr),    0);
      check("rst_data",     32'(fb_data),    0);
      check("rst_fd",       32'(frame_done), 0);
      check("rst_ovf",      32'(overflow),   0);
      check("rst_drop",     32'(drop_count), 0);
      rst = 1'b0;
      en  = 1'b1;
      ack = 1'b1;
      tick();
      check("idle_no_capture_we", 32'(fb_we), 0);

      // Basic capture and two-edge latency
      pix(8'd2, 8'd2, 6'h00, 1'b1);
      check("t1_not_early", 32'(fb_we), 0);
      pix(8'd3, 8'd2, 6'h15, 1'b1);
      tick();
      check("t1_we",   32'(fb_we),   1);
      check("t1_addr", 32'(fb_addr), 32'h0203);
      check("t1_data", 32'(fb_data), 32'h15);
      wait_drain("t1");

      // Clamped pointer held at (255,239): one write, one FRAME_DONE cycle
      w0 = n_writes;
      f0 = fd_total;
      pix(8'd255, 8'd239, 6'h2A, 1'b1);
      repeat (99) tick();
      check("t2_writes",   32'(n_writes - w0), 1);
      check("t2_fd_cycles", 32'(fd_total - f0), 1);
      check("t2_drop",     32'(drop_count), 0);
      wait_drain("t2");

      // Overflow: 40 new pixels with no acknowledge, 16 kept, 24 dropped
      ack = 1'b0;
      for (int i = 0; i < 40; i++) pix(8'(i), 8'd10, 6'(i), (i < 16));
      repeat (3) tick();
      check("t3_ovf",  32'(overflow),   1);
      check("t3_drop", 32'(drop_count), 24);
      check("t3_we",   32'(fb_we),      1);
      check("t3_head", 32'(fb_addr),    32'h0A00);
      ack = 1'b1;
      wait_drain("t3");
      check("t3_ovf_sticky",  32'(overflow),   1);
      check("t3_drop_sticky", 32'(drop_count), 24);

      // Stretched acknowledge: outputs stable, next entry right after the ack edge
      ack = 1'b0;
      for (int i = 0; i < 3; i++) pix(8'(i), 8'd20, 6'(8'h30 + i), 1'b1);
      for (int j = 0; j < 3; j++) begin
         repeat (3) begin
            tick();
            check("t4_hold_we",   32'(fb_we),   1);
            check("t4_hold_addr", 32'(fb_addr), 32'h1400 + j);
            check("t4_hold_data", 32'(fb_data), 32'h30 + j);
         end
         ack = 1'b1;
         tick();
         ack = 1'b0;
         if (j < 2) begin
            check("t4_next_we",   32'(fb_we),   1);
            check("t4_next_addr", 32'(fb_addr), 32'h1400 + j + 1);
         end else begin
            check("t4_last_we", 32'(fb_we), 0);
         end
      end
      wait_drain("t4");

      // Reset mid-request with 5 entries queued
      ack = 1'b0;
      for (int i = 0; i < 5; i++) pix(8'(i), 8'd30, 6'(i), 1'b0);
      tick();
      check("t5_we_before", 32'(fb_we), 1);
      #2;
      rst = 1'b1;
      #1;
      check("t5_async_we",   32'(fb_we),   0);
      check("t5_async_addr", 32'(fb_addr), 0);
      px = 8'd255;
      py = 8'd239;
      repeat (2) tick();
      rst = 1'b0;
      ack = 1'b1;
      w0  = n_writes;
      repeat (20) tick();
      check("t5_no_stale", 32'(n_writes - w0), 0);
      check("t5_we_after", 32'(fb_we),      0);
      check("t5_ovf_clr",  32'(overflow),   0);
      check("t5_drop_clr", 32'(drop_count), 0);
      pix(8'd0, 8'd0, 6'h11, 1'b1);
      wait_drain("t5");

      // ENABLE low with 4 entries queued: they drain, nothing new is captured
      ack = 1'b0;
      for (int i = 0; i < 4; i++) pix(8'(i), 8'd40, 6'(8'h20 + i), 1'b1);
      en  = 1'b0;
      ack = 1'b1;
      w0  = n_writes;
      for (int i = 0; i < 10; i++) pix(8'(10 + i), 8'd40, 6'h3F, 1'b0);
      wait_drain("t6");
      repeat (5) tick();
      check("t6_writes", 32'(n_writes - w0), 4);
      check("t6_we_idle", 32'(fb_we), 0);

      check("end_queue_empty", 32'(exp_q.size()), 0);
      check("end_fd_total",    32'(fd_total),     1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ppu_fb_writer.md
PPU_FB_WRITER -- requirements
Module: ppu_fb_writer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, giving the number of pending pixel entries; legal values are powers of two from 4 to 64.
REQ-002 SHALL have port PPU_SLOW_CLOCK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port ENABLE, input, 1 bit: capture enable; when low, no new pixels are accepted.
REQ-005 SHALL have port VGA_STREAM_DATA, input, 6 bits: the PPU output colour index for the current pixel.
REQ-006 SHALL have port PPU_PTR_X, input, 8 bits: current pixel column, clamped by the PPU to 255 outside the visible area.
REQ-007 SHALL have port PPU_PTR_Y, input, 8 bits: current scanline, clamped by the PPU to 239 outside the visible area.
REQ-008 SHALL have port FB_ADDR, output, 16 bits: frame-buffer write address.
REQ-009 SHALL have port FB_DATA, output, 6 bits: frame-buffer write data.
REQ-010 SHALL have port FB_WE, output, 1 bit: write request.
REQ-011 SHALL have port FB_ACK, input, 1 bit: write accepted by the memory.
REQ-012 SHALL have port FRAME_DONE, output, 1 bit: one-cycle pulse when the last visible pixel is accepted.
REQ-013 SHALL have port OVERFLOW, output, 1 bit: sticky flag set when a pixel is dropped.
REQ-014 SHALL have port DROP_COUNT, output, 8 bits: count of dropped pixels, saturating.

Function
REQ-015 SHALL keep the last-seen coordinate registers prev_x and prev_y, updated every cycle with PPU_PTR_X and PPU_PTR_Y regardless of ENABLE.
REQ-016 SHALL capture a pixel on a cycle when ENABLE=1 and {PPU_PTR_Y,PPU_PTR_X} differs from {prev_y,prev_x}; clamped blanking repeats are therefore written once only.
REQ-017 SHALL form each captured entry as address = {PPU_PTR_Y,PPU_PTR_X} (Y*256+X) plus the 6-bit data, and push it into the FIFO at the capturing edge.
REQ-018 SHALL drop a capture when the FIFO is full, even if a pop happens on the same edge, set OVERFLOW, and increment DROP_COUNT, saturating at 255.
REQ-019 SHALL implement a two-state write FSM with states IDLE and REQ.
REQ-020 In IDLE with the FIFO non-empty, SHALL pop the head entry into the FB_ADDR/FB_DATA registers, assert FB_WE, and go to REQ.
REQ-021 In REQ, SHALL hold FB_WE, FB_ADDR and FB_DATA stable until FB_ACK is sampled high.
REQ-022 In REQ with FB_ACK=1 and the FIFO non-empty, SHALL load the next entry and stay in REQ, sustaining one write per cycle.
REQ-023 In REQ with FB_ACK=1 and the FIFO empty, SHALL deassert FB_WE and return to IDLE.
REQ-024 SHALL ignore FB_ACK while FB_WE=0.
REQ-025 SHALL give a latency of 2 edges from a capture to FB_WE: the input is sampled at edge k and FB_WE is high after edge k+1 when the FIFO and FSM are idle.
REQ-026 SHALL allow push and pop on the same edge when the FIFO is neither full nor empty, with occupancy unchanged.
REQ-027 SHALL make FIFO read/write pointers wrap modulo FIFO_DEPTH, and distinguish full from empty with an extra pointer bit.
REQ-028 SHALL pulse FRAME_DONE high for exactly one cycle, on the edge after FB_ACK is accepted for address 0xEFFF (x=255, y=239).
REQ-029 On ENABLE falling, SHALL stop captures but drain entries already queued normally.
REQ-030 SHALL never clear OVERFLOW and DROP_COUNT except by RST.

Reset
REQ-031 RST=1 SHALL immediately and asynchronously force FB_WE=0, FB_ADDR=0, FB_DATA=0, FRAME_DONE=0, OVERFLOW=0, DROP_COUNT=0, FSM=IDLE, FIFO empty, prev_x=255, prev_y=239.
REQ-032 Reset during REQ SHALL abandon the pending write without waiting for FB_ACK, and queued entries SHALL be lost.
REQ-033 After RST is released, the first capture SHALL be possible at the first edge whose coordinate differs from (255,239).

Verification
REQ-034 Bench SHALL drive ENABLE=1, FB_ACK tied 1, and pointer (3,2) with data 0x15 after (2,2) -> FB_WE=1, FB_ADDR=0x0203, FB_DATA=0x15, 2 edges later.
REQ-035 Bench SHALL drive a pointer held at (255,239) for 100 cycles -> exactly one write, to 0xEFFF, and FRAME_DONE pulses once, 1 cycle wide.
REQ-036 Bench SHALL drive FB_ACK=0 for 40 new pixels with FIFO_DEPTH=16 -> 16 queued (one of them in the output register), OVERFLOW=1, DROP_COUNT=24, and the queued writes then drain in order once FB_ACK=1.
REQ-037 Bench SHALL stretch FB_ACK with a 3-cycle delay -> FB_ADDR and FB_DATA stay stable while FB_WE=1, and the next entry follows on the edge after the acknowledge.
REQ-038 Bench SHALL assert RST mid-REQ with 5 entries queued -> FB_WE drops with no clock edge, and no stale write appears after release.
REQ-039 Bench SHALL drive ENABLE low with 4 entries queued -> exactly 4 writes complete and no further captures occur.
